// File: rtl/multicycle_control_unit_pkg.sv
// rv_ctrl_pkg: shared encodings for the RV32I multi-cycle control unit.
//   - FSM state encodings (also exported on the debug 'state' port)
//   - base opcode constants, ExtSel / PCSrc / DBDataSrc codes
//   - ALU operation enum and instruction-class enum
//   - alu_from_funct(): funct3 (+ alternate bit) to ALU operation
package rv_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IF   = 3'b000,
    S_ID   = 3'b001,
    S_EXE  = 3'b010,
    S_MEM  = 3'b011,
    S_WB   = 3'b100,
    S_HALT = 3'b111
  } state_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [2:0] EXT_I     = 3'b000;
  localparam logic [2:0] EXT_S     = 3'b001;
  localparam logic [2:0] EXT_B     = 3'b010;
  localparam logic [2:0] EXT_U     = 3'b011;
  localparam logic [2:0] EXT_J     = 3'b100;
  localparam logic [2:0] EXT_SHAMT = 3'b101;

  localparam logic [1:0] PC_PLUS4 = 2'b00;
  localparam logic [1:0] PC_IMM   = 2'b01;
  localparam logic [1:0] PC_ALU   = 2'b10;

  localparam logic [1:0] DB_ALU = 2'b00;
  localparam logic [1:0] DB_MEM = 2'b01;
  localparam logic [1:0] DB_PC4 = 2'b10;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
    ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASSB
  } alu_op_e;

  typedef enum logic [3:0] {
    CLS_R, CLS_I, CLS_LOAD, CLS_STORE, CLS_BRANCH, CLS_JAL,
    CLS_JALR, CLS_LUI, CLS_AUIPC, CLS_HALT, CLS_BAD
  } cls_e;

  // alt selects SUB (funct3 000) or SRA (funct3 101); ignored otherwise.
  function automatic alu_op_e alu_from_funct(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_control_unit_if.sv
// multicycle_control_unit_if: bundle between the control unit and datapath.
//   IR fields / flags : opcode, funct3, funct7_5, Zero, Lt   (datapath -> ctrl)
//   enables           : PCWre, IRWre, RegWre, mRD, mWR       (ctrl -> datapath)
//   selects           : ALUSrcA, ALUSrcB, ALUOp, ExtSel, Sign, PCSrc, DBDataSrc
//   debug             : state
// master = control unit, slave = datapath.
interface multicycle_control_unit_if;
  import rv_ctrl_pkg::*;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_5;
  logic       Zero;
  logic       Lt;
  logic       PCWre;
  logic       IRWre;
  logic       RegWre;
  logic       mRD;
  logic       mWR;
  logic       ALUSrcA;
  logic       ALUSrcB;
  alu_op_e    ALUOp;
  logic [2:0] ExtSel;
  logic       Sign;
  logic [1:0] PCSrc;
  logic [1:0] DBDataSrc;
  logic [2:0] state;

  modport master (
    input  opcode, funct3, funct7_5, Zero, Lt,
    output PCWre, IRWre, RegWre, mRD, mWR, ALUSrcA, ALUSrcB, ALUOp,
           ExtSel, Sign, PCSrc, DBDataSrc, state
  );

  modport slave (
    output opcode, funct3, funct7_5, Zero, Lt,
    input  PCWre, IRWre, RegWre, mRD, mWR, ALUSrcA, ALUSrcB, ALUOp,
           ExtSel, Sign, PCSrc, DBDataSrc, state
  );
endinterface

// File: rtl/multicycle_control_unit_ctrl_decode.sv
// ctrl_decode: combinational instruction decode.
//   opcode_i, funct3_i, funct7_5_i : IR fields
//   cls_o     : instruction class (CLS_HALT for HALT_OPCODE, CLS_BAD if unknown)
//   ext_sel_o : immediate format, sign_o : sign-extend enable
//   alu_op_o  : ALU operation for the EXE/MEM address phase
module ctrl_decode
  import rv_ctrl_pkg::*;
#(
  parameter logic [6:0] HALT_OPCODE = 7'b1110011
) (
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7_5_i,
  output cls_e       cls_o,
  output logic [2:0] ext_sel_o,
  output logic       sign_o,
  output alu_op_e    alu_op_o
);

  always_comb begin
    cls_o     = CLS_BAD;
    ext_sel_o = EXT_I;
    sign_o    = 1'b0;
    alu_op_o  = ALU_ADD;
    if (opcode_i == HALT_OPCODE) begin
      cls_o = CLS_HALT;
    end else begin
      case (opcode_i)
        OP_R: begin
          cls_o    = CLS_R;
          alu_op_o = alu_from_funct(funct3_i, funct7_5_i);
        end
        OP_I: begin
          cls_o = CLS_I;
          // funct7_5 only matters for SRAI; ADDI never becomes SUB.
          alu_op_o = alu_from_funct(funct3_i, funct7_5_i && (funct3_i == 3'b101));
          if (funct3_i == 3'b001 || funct3_i == 3'b101) begin
            ext_sel_o = EXT_SHAMT;
            sign_o    = 1'b0;
          end else begin
            ext_sel_o = EXT_I;
            sign_o    = 1'b1;
          end
        end
        OP_LOAD: begin
          cls_o  = CLS_LOAD;
          sign_o = 1'b1;
        end
        OP_STORE: begin
          cls_o     = CLS_STORE;
          ext_sel_o = EXT_S;
          sign_o    = 1'b1;
        end
        OP_BRANCH: begin
          cls_o     = CLS_BRANCH;
          ext_sel_o = EXT_B;
          sign_o    = 1'b1;
          case (funct3_i[2:1])
            2'b10:   alu_op_o = ALU_SLT;
            2'b11:   alu_op_o = ALU_SLTU;
            default: alu_op_o = ALU_SUB;
          endcase
        end
        OP_JAL: begin
          cls_o     = CLS_JAL;
          ext_sel_o = EXT_J;
          sign_o    = 1'b1;
        end
        OP_JALR: begin
          cls_o  = CLS_JALR;
          sign_o = 1'b1;
        end
        OP_LUI: begin
          cls_o     = CLS_LUI;
          ext_sel_o = EXT_U;
          alu_op_o  = ALU_PASSB;
        end
        OP_AUIPC: begin
          cls_o     = CLS_AUIPC;
          ext_sel_o = EXT_U;
        end
        default: cls_o = CLS_BAD;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: Moore FSM sequencing the RV32I multi-cycle datapath.
//   CLK     : system clock, rising edge
//   Reset   : asynchronous, active-high; forces IF and zeroes all outputs
//   ctrl_if : master side of multicycle_control_unit_if (IR fields and flags
//             in; enables, selects and debug state out)
module multicycle_control_unit
  import rv_ctrl_pkg::*;
#(
  parameter logic [6:0] HALT_OPCODE = 7'b1110011
) (
  input  logic                        CLK,
  input  logic                        Reset,
  multicycle_control_unit_if.master   ctrl_if
);

  state_e     state_q, state_d;
  cls_e       cls;
  logic [2:0] ext_sel;
  logic       sign;
  alu_op_e    alu_op;
  logic       br_taken;

  ctrl_decode #(.HALT_OPCODE(HALT_OPCODE)) u_decode (
    .opcode_i   (ctrl_if.opcode),
    .funct3_i   (ctrl_if.funct3),
    .funct7_5_i (ctrl_if.funct7_5),
    .cls_o      (cls),
    .ext_sel_o  (ext_sel),
    .sign_o     (sign),
    .alu_op_o   (alu_op)
  );

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) state_q <= S_IF;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IF:  state_d = S_ID;
      S_ID:  state_d = (cls == CLS_HALT || cls == CLS_BAD) ? S_HALT : S_EXE;
      S_EXE: begin
        if (cls == CLS_LOAD || cls == CLS_STORE) state_d = S_MEM;
        else if (cls == CLS_BRANCH)              state_d = S_IF;
        else                                     state_d = S_WB;
      end
      S_MEM:  state_d = (cls == CLS_LOAD) ? S_WB : S_IF;
      S_WB:   state_d = S_IF;
      S_HALT: state_d = S_HALT;
      default: state_d = S_IF;
    endcase
  end

  always_comb begin
    case (ctrl_if.funct3)
      3'b000:        br_taken = ctrl_if.Zero;
      3'b001:        br_taken = ~ctrl_if.Zero;
      3'b100, 3'b110: br_taken = ctrl_if.Lt;
      3'b101, 3'b111: br_taken = ~ctrl_if.Lt;
      default:       br_taken = 1'b0;
    endcase
  end

  assign ctrl_if.state = state_q;

  // Outputs are gated by Reset directly so a mid-instruction reset drops
  // every enable in the same cycle, not at the next clock edge.
  always_comb begin
    ctrl_if.PCWre     = 1'b0;
    ctrl_if.IRWre     = 1'b0;
    ctrl_if.RegWre    = 1'b0;
    ctrl_if.mRD       = 1'b0;
    ctrl_if.mWR       = 1'b0;
    ctrl_if.ALUSrcA   = 1'b0;
    ctrl_if.ALUSrcB   = 1'b0;
    ctrl_if.ALUOp     = ALU_ADD;
    ctrl_if.ExtSel    = '0;
    ctrl_if.Sign      = 1'b0;
    ctrl_if.PCSrc     = PC_PLUS4;
    ctrl_if.DBDataSrc = DB_ALU;
    if (!Reset) begin
      ctrl_if.ALUOp   = alu_op;
      ctrl_if.ExtSel  = ext_sel;
      ctrl_if.Sign    = sign;
      ctrl_if.ALUSrcA = (cls == CLS_AUIPC);
      ctrl_if.ALUSrcB = (cls == CLS_I) || (cls == CLS_LOAD) || (cls == CLS_STORE) ||
                        (cls == CLS_LUI) || (cls == CLS_AUIPC) || (cls == CLS_JALR);
      if (cls == CLS_LOAD)                         ctrl_if.DBDataSrc = DB_MEM;
      else if (cls == CLS_JAL || cls == CLS_JALR)  ctrl_if.DBDataSrc = DB_PC4;
      case (state_q)
        S_IF: ctrl_if.IRWre = 1'b1;
        S_EXE: begin
          if (cls == CLS_BRANCH) begin
            ctrl_if.PCWre = 1'b1;
            ctrl_if.PCSrc = br_taken ? PC_IMM : PC_PLUS4;
          end
        end
        S_MEM: begin
          if (cls == CLS_LOAD) begin
            ctrl_if.mRD = 1'b1;
          end else if (cls == CLS_STORE) begin
            ctrl_if.mWR   = 1'b1;
            ctrl_if.PCWre = 1'b1;
          end
        end
        S_WB: begin
          ctrl_if.RegWre = 1'b1;
          ctrl_if.PCWre  = 1'b1;
          if (cls == CLS_JAL)       ctrl_if.PCSrc = PC_IMM;
          else if (cls == CLS_JALR) ctrl_if.PCSrc = PC_ALU;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench: the stimulus pushes one expected output record per clock
// cycle; the monitor pops and compares at every falling edge.
module tb_multicycle_control_unit;
  import rv_ctrl_pkg::*;

  logic CLK = 1'b0;
  logic Reset = 1'b1;
  multicycle_control_unit_if ifc();

  multicycle_control_unit #(.HALT_OPCODE(7'b1110011)) dut (
    .CLK     (CLK),
    .Reset   (Reset),
    .ctrl_if (ifc)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [63:0] nm;
    logic [2:0]  st;
    logic [4:0]  en;     // {PCWre, IRWre, RegWre, mRD, mWR}
    bit          ca;
    logic        a, b;
    alu_op_e     op;
    bit          cx;
    logic [2:0]  ext;
    logic        sg;
    bit          cp;
    logic [1:0]  pcs;
    bit          cd;
    logic [1:0]  db;
  } exp_t;

  exp_t q[$];
  int unsigned checks = 0;
  int unsigned passed = 0;

  localparam logic [2:0] SIF = 3'd0, SID = 3'd1, SEX = 3'd2, SME = 3'd3, SWB = 3'd4, SHA = 3'd7;
  localparam logic [4:0] N = 5'b00000, IRW = 5'b01000, WBE = 5'b10100,
                         PCW = 5'b10000, RD = 5'b00010, WR = 5'b10001;

  localparam logic [31:0] I_ADD  = 32'h00C58533, I_LW   = 32'h0045A503,
                          I_SW   = 32'h00A5A223, I_BNE  = 32'hFE059EE3,
                          I_JAL  = 32'h008000EF, I_JALR = 32'h000280E7,
                          I_SRAI = 32'h4035D513, I_ECAL = 32'h00000073,
                          I_ILL  = 32'h00000000;

  function automatic exp_t E(input logic [63:0] nm, input logic [2:0] st, input logic [4:0] en);
    exp_t e;
    e.nm = nm; e.st = st; e.en = en;
    e.ca = 0; e.a = 0; e.b = 0; e.op = ALU_ADD;
    e.cx = 0; e.ext = '0; e.sg = 0;
    e.cp = 0; e.pcs = '0; e.cd = 0; e.db = '0;
    return e;
  endfunction
  function automatic exp_t A(input exp_t e, input alu_op_e op, input logic a, input logic b);
    e.ca = 1; e.op = op; e.a = a; e.b = b; return e;
  endfunction
  function automatic exp_t X(input exp_t e, input logic [2:0] ext, input logic sg);
    e.cx = 1; e.ext = ext; e.sg = sg; return e;
  endfunction
  function automatic exp_t P(input exp_t e, input logic [1:0] pcs);
    e.cp = 1; e.pcs = pcs; return e;
  endfunction
  function automatic exp_t D(input exp_t e, input logic [1:0] db);
    e.cd = 1; e.db = db; return e;
  endfunction
  // every select must read zero (reset)
  function automatic exp_t R0(input exp_t e);
    return D(P(X(A(e, ALU_ADD, 1'b0, 1'b0), 3'b000, 1'b0), 2'b00), 2'b00);
  endfunction

  task automatic cmp(input logic [63:0] nm, input string what, input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got === want) passed++;
    else $display("FAIL %0s %0s: got %h want %h", nm, what, got, want);
  endtask

  task automatic check(input exp_t e);
    cmp(e.nm, "state/en", {8'd0, ifc.state, ifc.PCWre, ifc.IRWre, ifc.RegWre, ifc.mRD, ifc.mWR},
        {8'd0, e.st, e.en});
    if (e.ca) cmp(e.nm, "alu{A,B,op}", {10'd0, ifc.ALUSrcA, ifc.ALUSrcB, ifc.ALUOp},
                  {10'd0, e.a, e.b, e.op});
    if (e.cx) cmp(e.nm, "ext{sel,sign}", {12'd0, ifc.ExtSel, ifc.Sign}, {12'd0, e.ext, e.sg});
    if (e.cp) cmp(e.nm, "PCSrc", {14'd0, ifc.PCSrc}, {14'd0, e.pcs});
    if (e.cd) cmp(e.nm, "DBDataSrc", {14'd0, ifc.DBDataSrc}, {14'd0, e.db});
  endtask

  // monitor
  initial begin
    forever begin
      @(negedge CLK);
      if (q.size() > 0) check(q.pop_front());
    end
  end

  task automatic cyc(input logic [31:0] ir, input logic z, input logic rst, input exp_t e);
    @(posedge CLK);
    #1;
    Reset        = rst;
    ifc.opcode   = ir[6:0];
    ifc.funct3   = ir[14:12];
    ifc.funct7_5 = ir[30];
    ifc.Zero     = z;
    ifc.Lt       = 1'b0;
    q.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, got timeout want completion");
    $fatal(1);
  end

  initial begin
    ifc.opcode = I_ADD[6:0]; ifc.funct3 = '0; ifc.funct7_5 = 1'b0;
    ifc.Zero = 1'b0; ifc.Lt = 1'b0;

    // reset: selects forced to zero even with JAL (nonzero ExtSel/Sign/DB) held
    cyc(I_JAL, 0, 1, R0(E("RST_JAL", SIF, N)));
    cyc(I_ADD, 0, 1, R0(E("RST_ADD", SIF, N)));

    // ADD: IF ID EXE WB
    cyc(I_ADD, 0, 0, E("ADD", SIF, IRW));
    cyc(I_ADD, 0, 0, E("ADD", SID, N));
    cyc(I_ADD, 0, 0, A(E("ADD", SEX, N), ALU_ADD, 0, 0));
    cyc(I_ADD, 0, 0, D(P(E("ADD", SWB, WBE), 2'b00), 2'b00));

    // LW: 5 cycles
    cyc(I_LW, 0, 0, E("LW", SIF, IRW));
    cyc(I_LW, 0, 0, X(E("LW", SID, N), 3'b000, 1));
    cyc(I_LW, 0, 0, X(A(E("LW", SEX, N), ALU_ADD, 0, 1), 3'b000, 1));
    cyc(I_LW, 0, 0, X(E("LW", SME, RD), 3'b000, 1));
    cyc(I_LW, 0, 0, X(D(P(E("LW", SWB, WBE), 2'b00), 2'b01), 3'b000, 1));

    // SW: 4 cycles
    cyc(I_SW, 0, 0, E("SW", SIF, IRW));
    cyc(I_SW, 0, 0, X(E("SW", SID, N), 3'b001, 1));
    cyc(I_SW, 0, 0, X(A(E("SW", SEX, N), ALU_ADD, 0, 1), 3'b001, 1));
    cyc(I_SW, 0, 0, X(P(E("SW", SME, WR), 2'b00), 3'b001, 1));

    // BNE taken (Zero=0): 3 cycles
    cyc(I_BNE, 0, 0, E("BNE_T", SIF, IRW));
    cyc(I_BNE, 0, 0, X(E("BNE_T", SID, N), 3'b010, 1));
    cyc(I_BNE, 0, 0, X(P(A(E("BNE_T", SEX, PCW), ALU_SUB, 0, 0), 2'b01), 3'b010, 1));

    // BNE not taken (Zero=1)
    cyc(I_BNE, 1, 0, E("BNE_N", SIF, IRW));
    cyc(I_BNE, 1, 0, E("BNE_N", SID, N));
    cyc(I_BNE, 1, 0, P(E("BNE_N", SEX, PCW), 2'b00));

    // JAL
    cyc(I_JAL, 0, 0, E("JAL", SIF, IRW));
    cyc(I_JAL, 0, 0, X(E("JAL", SID, N), 3'b100, 1));
    cyc(I_JAL, 0, 0, X(E("JAL", SEX, N), 3'b100, 1));
    cyc(I_JAL, 0, 0, X(D(P(E("JAL", SWB, WBE), 2'b01), 2'b10), 3'b100, 1));

    // JALR
    cyc(I_JALR, 0, 0, E("JALR", SIF, IRW));
    cyc(I_JALR, 0, 0, X(E("JALR", SID, N), 3'b000, 1));
    cyc(I_JALR, 0, 0, X(A(E("JALR", SEX, N), ALU_ADD, 0, 1), 3'b000, 1));
    cyc(I_JALR, 0, 0, D(P(E("JALR", SWB, WBE), 2'b10), 2'b10));

    // SRAI
    cyc(I_SRAI, 0, 0, E("SRAI", SIF, IRW));
    cyc(I_SRAI, 0, 0, X(E("SRAI", SID, N), 3'b101, 0));
    cyc(I_SRAI, 0, 0, X(A(E("SRAI", SEX, N), ALU_SRA, 0, 1), 3'b101, 0));
    cyc(I_SRAI, 0, 0, D(P(E("SRAI", SWB, WBE), 2'b00), 2'b00));

    // SW interrupted by reset in MEM, then rerun
    cyc(I_SW, 0, 0, E("SW_R", SIF, IRW));
    cyc(I_SW, 0, 0, E("SW_R", SID, N));
    cyc(I_SW, 0, 0, E("SW_R", SEX, N));
    cyc(I_SW, 0, 1, R0(E("SW_RST", SIF, N)));
    cyc(I_SW, 0, 0, E("SW_R", SIF, IRW));
    cyc(I_SW, 0, 0, E("SW_R", SID, N));
    cyc(I_SW, 0, 0, E("SW_R", SEX, N));
    cyc(I_SW, 0, 0, E("SW_R", SME, WR));

    // ECALL parks in HALT
    cyc(I_ECAL, 0, 0, E("ECALL", SIF, IRW));
    cyc(I_ECAL, 0, 0, E("ECALL", SID, N));
    for (int unsigned i = 0; i < 12; i++) cyc(I_ECAL, 0, 0, E("ECALL", SHA, N));
    cyc(I_ILL, 0, 1, R0(E("HLT_RST", SIF, N)));

    // unknown opcode also parks in HALT
    cyc(I_ILL, 0, 0, E("ILLEGAL", SIF, IRW));
    cyc(I_ILL, 0, 0, E("ILLEGAL", SID, N));
    for (int unsigned i = 0; i < 11; i++) cyc(I_ILL, 0, 0, E("ILLEGAL", SHA, N));
    cyc(I_ILL, 0, 1, E("ILL_RST", SIF, N));
    cyc(I_ADD, 0, 0, E("RESUME", SIF, IRW));
    cyc(I_ADD, 0, 0, E("RESUME", SID, N));

    repeat (2) @(negedge CLK);
    cmp("END", "queue_left", q.size(), 16'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
